// File: rtl/aq_iu_div_pkg.sv
// Shared constants, state encoding and operand-extension helper for the lc164 divide controller.
package aq_iu_div_pkg;

    localparam int unsigned DIV_W = 64;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PREP0 = 3'd1;
    localparam logic [2:0] PREP1 = 3'd2;
    localparam logic [2:0] ALIGN = 3'd3;
    localparam logic [2:0] ITER  = 3'd4;
    localparam logic [2:0] FIX   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic [DIV_W-1:0] DIV_ALL_ONES  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_INT64_MIN = {1'b1, {(DIV_W-1){1'b0}}};
    localparam logic [DIV_W-1:0] DIV_INT32_MIN = {{(DIV_W-31){1'b1}}, {31{1'b0}}};

    // W forms only look at bits [31:0]; extend them to the full width.
    function automatic logic [DIV_W-1:0] div_word_ext(input logic [DIV_W-1:0] v,
                                                      input logic             word,
                                                      input logic             sext);
        return word ? {{(DIV_W-32){sext & v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/aq_iu_div_fixup.sv
// Combinational operand/result conditioning: word extend, absolute value or negate, result
// sign-extension from bit 31.
module aq_iu_div_fixup
    import aq_iu_div_pkg::*;
(
    input  logic [DIV_W-1:0] din,
    input  logic             word,
    input  logic             sext_in,
    input  logic             abs_en,
    input  logic             neg_en,
    input  logic             sext_out,
    output logic [DIV_W-1:0] dout
);

    logic [DIV_W-1:0] ext;
    logic [DIV_W-1:0] mag;
    logic             do_neg;

    always_comb begin
        ext    = div_word_ext(din, word, sext_in);
        do_neg = neg_en | (abs_en & ext[DIV_W-1]);
        mag    = do_neg ? -ext : ext;
        // Result magnitudes are zero-extended before negation so that -2^31 survives in W form.
        dout   = (word & sext_out) ? div_word_ext(mag, 1'b1, 1'b1) : mag;
    end

endmodule

// File: rtl/aq_iu_div_ctrl.sv
// Sequencing controller for the radix-4 shift-subtract divide kernel: owns the working
// registers, drives the kernel strobes and returns one fixed-up result per request.
module aq_iu_div_ctrl #(
    parameter int unsigned DIV_W = 64
) (
    input  logic             div_clk,
    input  logic             cpurst_b,
    input  logic             ex_div_start,
    output logic             ex_div_ready,
    input  logic             ex_div_signed,
    input  logic             ex_div_word,
    input  logic             ex_div_rem,
    input  logic [DIV_W-1:0] ex_div_src0,
    input  logic [DIV_W-1:0] ex_div_src1,
    input  logic             rtu_flush,
    output logic             div_rslt_vld,
    input  logic             div_rslt_ack,
    output logic [DIV_W-1:0] div_rslt_data,
    output logic             div_prepare_src0,
    output logic             div_prepare_src1,
    output logic             div_align,
    output logic             div_iterating,
    input  logic             div_iter_cmplt,
    output logic [DIV_W-1:0] div_ff1_src,
    output logic [DIV_W-1:0] div_divisor_reg,
    output logic [DIV_W-1:0] div_remainder_reg,
    output logic [DIV_W-1:0] div_quotient_reg,
    input  logic [DIV_W-1:0] div_divisor_update_data,
    input  logic [DIV_W-1:0] div_remainder_reg_updt,
    input  logic [DIV_W-1:0] div_quotient_reg_updt
);

    import aq_iu_div_pkg::*;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] divisor_q, remainder_q, quotient_q, rslt_q;
    logic             signed_q, word_q, rem_q, q_neg_q, r_neg_q;

    logic [DIV_W-1:0] ext0, ext1, abs0, abs1, fix_val, fix_sel;
    logic             sign0, sign1, div_zero, ovf, special, accept, fix_neg;

    aq_iu_div_fixup u_cond0 (
        .din      (ex_div_src0),
        .word     (ex_div_word),
        .sext_in  (ex_div_signed),
        .abs_en   (ex_div_signed),
        .neg_en   (1'b0),
        .sext_out (1'b0),
        .dout     (abs0)
    );

    aq_iu_div_fixup u_cond1 (
        .din      (ex_div_src1),
        .word     (ex_div_word),
        .sext_in  (ex_div_signed),
        .abs_en   (ex_div_signed),
        .neg_en   (1'b0),
        .sext_out (1'b0),
        .dout     (abs1)
    );

    always_comb begin
        ext0     = div_word_ext(ex_div_src0, ex_div_word, ex_div_signed);
        ext1     = div_word_ext(ex_div_src1, ex_div_word, ex_div_signed);
        sign0    = ex_div_signed & ext0[DIV_W-1];
        sign1    = ex_div_signed & ext1[DIV_W-1];
        div_zero = (ext1 == '0);
        ovf      = ex_div_signed & (ext1 == DIV_ALL_ONES)
                   & (ext0 == (ex_div_word ? DIV_INT32_MIN : DIV_INT64_MIN));
        special  = div_zero | ovf;
    end

    assign ex_div_ready = (state_q == IDLE) & ~rtu_flush;
    assign accept       = ex_div_start & ex_div_ready;

    always_comb begin
        fix_sel = rem_q ? remainder_q : quotient_q;
        fix_neg = signed_q & (rem_q ? r_neg_q : q_neg_q);
    end

    aq_iu_div_fixup u_fix (
        .din      (fix_sel),
        .word     (word_q),
        .sext_in  (1'b0),
        .abs_en   (1'b0),
        .neg_en   (fix_neg),
        .sext_out (1'b1),
        .dout     (fix_val)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? FIX : PREP0;
            PREP0:   state_d = PREP1;
            PREP1:   state_d = ALIGN;
            ALIGN:   state_d = ITER;
            ITER:    if (div_iter_cmplt) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (div_rslt_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rtu_flush) state_d = IDLE;
    end

    // Strobes come from state only; flush gates them in the same cycle.
    always_comb begin
        div_prepare_src0 = (state_q == PREP0) & ~rtu_flush;
        div_prepare_src1 = (state_q == PREP1) & ~rtu_flush;
        div_align        = (state_q == ALIGN) & ~rtu_flush;
        div_iterating    = (state_q == ITER)  & ~rtu_flush;
        div_rslt_vld     = (state_q == DONE)  & ~rtu_flush;
        case (state_q)
            PREP0:   div_ff1_src = remainder_q;
            PREP1:   div_ff1_src = divisor_q;
            default: div_ff1_src = '0;
        endcase
    end

    always_ff @(posedge div_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge div_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            divisor_q   <= '0;
            remainder_q <= '0;
            quotient_q  <= '0;
            rslt_q      <= '0;
            signed_q    <= 1'b0;
            word_q      <= 1'b0;
            rem_q       <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
        end else begin
            if (accept) begin
                signed_q  <= ex_div_signed;
                word_q    <= ex_div_word;
                rem_q     <= ex_div_rem;
                divisor_q <= abs1;
                // Special cases preload the final raw answer and suppress sign fix-up.
                if (div_zero) begin
                    remainder_q <= ext0;
                    quotient_q  <= DIV_ALL_ONES;
                    q_neg_q     <= 1'b0;
                    r_neg_q     <= 1'b0;
                end else if (ovf) begin
                    remainder_q <= '0;
                    quotient_q  <= ext0;
                    q_neg_q     <= 1'b0;
                    r_neg_q     <= 1'b0;
                end else begin
                    remainder_q <= abs0;
                    quotient_q  <= '0;
                    q_neg_q     <= sign0 ^ sign1;
                    r_neg_q     <= sign0;
                end
            end
            if (div_align) begin
                divisor_q <= div_divisor_update_data;
            end
            if (div_iterating) begin
                divisor_q   <= div_divisor_update_data;
                remainder_q <= div_remainder_reg_updt;
                quotient_q  <= div_quotient_reg_updt;
            end
            if ((state_q == FIX) && !rtu_flush) begin
                rslt_q <= fix_val;
            end
        end
    end

    assign div_rslt_data     = rslt_q;
    assign div_divisor_reg   = divisor_q;
    assign div_remainder_reg = remainder_q;
    assign div_quotient_reg  = quotient_q;

endmodule

// File: tb/tb_aq_iu_div_ctrl.sv
// Bench for aq_iu_div_ctrl: behavioural radix-4 kernel peer plus arithmetic reference model.
module tb_aq_iu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, ready, sgn = 1'b0, word = 1'b0, rem = 1'b0;
    logic [63:0] src0 = '0, src1 = '0;
    logic        flush = 1'b0, vld, ack = 1'b0;
    logic [63:0] rdata;
    logic        p0, p1, al, it, k_cmplt;
    logic [63:0] ff1_src, dvs_reg, rem_reg, quo_reg;
    logic [63:0] k_div, k_rem, k_quo, k_digit;

    int n_cmp = 0;
    int n_bad = 0;
    int strb_q[$];
    int ff1a = 0, ff1b = 0, k_cnt = 0, k_n;

    always #5 clk = ~clk;

    aq_iu_div_ctrl #(.DIV_W(64)) dut (
        .div_clk                 (clk),
        .cpurst_b                (rst_n),
        .ex_div_start            (start),
        .ex_div_ready            (ready),
        .ex_div_signed           (sgn),
        .ex_div_word             (word),
        .ex_div_rem              (rem),
        .ex_div_src0             (src0),
        .ex_div_src1             (src1),
        .rtu_flush               (flush),
        .div_rslt_vld            (vld),
        .div_rslt_ack            (ack),
        .div_rslt_data           (rdata),
        .div_prepare_src0        (p0),
        .div_prepare_src1        (p1),
        .div_align               (al),
        .div_iterating           (it),
        .div_iter_cmplt          (k_cmplt),
        .div_ff1_src             (ff1_src),
        .div_divisor_reg         (dvs_reg),
        .div_remainder_reg       (rem_reg),
        .div_quotient_reg        (quo_reg),
        .div_divisor_update_data (k_div),
        .div_remainder_reg_updt  (k_rem),
        .div_quotient_reg_updt   (k_quo)
    );

    function automatic int ff1(input logic [63:0] x);
        for (int i = 63; i >= 0; i--) if (x[i]) return i;
        return -1;
    endfunction

    // Kernel peer: radix-4 restoring division, two quotient bits per iterate strobe.
    always @(posedge clk) begin
        if (p0) ff1a <= ff1(ff1_src);
        if (p1) ff1b <= ff1(ff1_src);
        if (al) k_cnt <= 0;
        else if (it) k_cnt <= k_cnt + 1;
    end

    always_comb begin
        k_n     = (ff1a - ff1b < 0) ? 1 : (ff1a - ff1b + 2) / 2;
        k_div   = dvs_reg;
        k_rem   = rem_reg;
        k_quo   = quo_reg;
        k_digit = '0;
        k_cmplt = 1'b0;
        if (al) k_div = dvs_reg << (2 * k_n - 2);
        if (it) begin
            if (dvs_reg != '0) k_digit = rem_reg / dvs_reg;
            k_rem   = rem_reg - k_digit * dvs_reg;
            k_quo   = {quo_reg[61:0], k_digit[1:0]};
            k_div   = dvs_reg >> 2;
            k_cmplt = (k_cnt == k_n - 1);
        end
    end

    function automatic logic [63:0] wext(input logic [63:0] v, input bit w, input bit s);
        if (!w) return v;
        return s ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
    endfunction

    function automatic bit is_special(input logic [63:0] a0, b0, input bit s, w);
        logic [63:0] a, b, mn;
        a  = wext(a0, w, s);
        b  = wext(b0, w, s);
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        return (b == 64'd0) || (s && a == mn && b == '1);
    endfunction

    function automatic logic [63:0] ref_div(input logic [63:0] a0, b0, input bit s, w, r);
        logic [63:0] a, b, res;
        logic signed [63:0] sa, sb;
        a  = wext(a0, w, s);
        b  = wext(b0, w, s);
        sa = a;
        sb = b;
        if (b == 64'd0) res = r ? a : '1;
        else if (is_special(a0, b0, s, w)) res = r ? 64'd0 : a;
        else if (s) res = r ? sa % sb : sa / sb;
        else res = r ? a % b : a / b;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    // Expected ITER count; 0 means the request takes the special path.
    function automatic int exp_n(input logic [63:0] a0, b0, input bit s, w);
        logic [63:0] a, b;
        int d;
        if (is_special(a0, b0, s, w)) return 0;
        a = wext(a0, w, s);
        b = wext(b0, w, s);
        if (s && a[63]) a = -a;
        if (s && b[63]) b = -b;
        d = ff1(a) - ff1(b);
        return (d < 0) ? 1 : (d + 2) / 2;
    endfunction

    function automatic int exp_code(input int k, input int n);
        if (n == 0) return 0;
        if (k <= 3) return k;
        if (k <= 3 + n) return 4;
        return 0;
    endfunction

    function automatic int strobe_code();
        logic [3:0] sb;
        sb = {it, al, p1, p0};
        if ($countones(sb) > 1) return 7;
        if (sb[0]) return 1;
        if (sb[1]) return 2;
        if (sb[2]) return 3;
        if (sb[3]) return 4;
        return 0;
    endfunction

    task automatic issue(input logic [63:0] a, b, input bit s, w, r);
        @(negedge clk);
        src0  = a;
        src1  = b;
        sgn   = s;
        word  = w;
        rem   = r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one request to completion, acking in the cycle vld first appears.
    task automatic do_op(input logic [63:0] a, b, input bit s, w, r,
                         output logic [63:0] res, output int lat, output bit to);
        issue(a, b, s, w, r);
        strb_q.delete();
        to  = 1'b1;
        lat = 0;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            strb_q.push_back(strobe_code());
            if (vld) begin
                lat = k;
                res = rdata;
                to  = 1'b0;
                break;
            end
        end
        if (!to) begin
            ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld); end
        n_cmp++; if (rdata !== 64'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", rdata); end
        n_cmp++; if ({p0, p1, al, it} !== 4'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 0000", {p0, p1, al, it});
        end
        n_cmp++; if ({dvs_reg, rem_reg, quo_reg} !== 192'd0) begin
            n_bad++; $display("FAIL reset_regs got %h/%h/%h want 0", dvs_reg, rem_reg, quo_reg);
        end
    endtask

    // Directed case with result, latency and strobe-sequence checks.
    task automatic test_case(input string name, input logic [63:0] a, b, input bit s, w, r,
                             input logic [63:0] want);
        logic [63:0] res;
        int lat, n, bad_seq;
        bit to;
        n = exp_n(a, b, s, w);
        do_op(a, b, s, w, r, res, lat, to);
        n_cmp++; if (to || res !== want) begin
            n_bad++; $display("FAIL %s_result got %h (timeout=%0d) want %h", name, res, to, want);
        end
        n_cmp++; if (lat !== ((n == 0) ? 2 : 5 + n)) begin
            n_bad++; $display("FAIL %s_latency got %0d want %0d", name, lat, (n == 0) ? 2 : 5 + n);
        end
        bad_seq = 0;
        foreach (strb_q[i]) if (strb_q[i] != exp_code(i + 1, n)) bad_seq++;
        n_cmp++; if (bad_seq !== 0) begin
            n_bad++; $display("FAIL %s_strobes got %0d bad cycles want 0", name, bad_seq);
        end
    endtask

    task automatic test_directed();
        test_case("u100d7_q", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14);
        test_case("u100d7_r", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2);
        test_case("s_m7d2_q", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        test_case("s_m7d2_r", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        test_case("dz_q", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        test_case("dz_r", 64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'd5);
        test_case("ovf_q", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
        test_case("ovf_r", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1, 64'd0);
        test_case("ovfw_q", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
        test_case("lt_q", 64'd3, 64'd1000, 1'b0, 1'b0, 1'b0, 64'd0);
        test_case("lt_r", 64'd3, 64'd1000, 1'b0, 1'b0, 1'b1, 64'd3);
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat, seen;
        bit to;
        issue('1, 64'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++; if (it !== 1'b1) begin n_bad++; $display("FAIL flush_in_iter got %b want 1", it); end
        flush = 1'b1;
        #1;
        n_cmp++; if ({p0, p1, al, it, ready} !== 5'b0) begin
            n_bad++; $display("FAIL flush_gate got %b want 00000", {p0, p1, al, it, ready});
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || vld !== 1'b0) begin
            n_bad++; $display("FAIL flush_idle got ready=%b vld=%b want 1/0", ready, vld);
        end
        seen = 0;
        repeat (10) begin @(negedge clk); if (vld) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_vld got %0d want 0", seen); end
        do_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat, to);
        n_cmp++; if (to || res !== 64'd3) begin
            n_bad++; $display("FAIL flush_next got %h want 3", res);
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] held;
        int k;
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (vld) break;
        end
        n_cmp++; if (vld !== 1'b1 || rdata !== 64'd14) begin
            n_bad++; $display("FAIL bp_first got vld=%b data=%h want 1/e", vld, rdata);
        end
        held = rdata;
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (vld !== 1'b1 || rdata !== held || ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold got vld=%b data=%h ready=%b want 1/%h/0",
                                  vld, rdata, ready, held);
            end
        end
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || vld !== 1'b0) begin
            n_bad++; $display("FAIL bp_release got ready=%b vld=%b want 1/0", ready, vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1, r2;
        int l1, l2;
        bit t1, t2;
        do_op(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, r1, l1, t1);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", ready); end
        do_op(-64'sd1000, 64'd7, 1'b1, 1'b0, 1'b1, r2, l2, t2);
        n_cmp++; if (t1 || r1 !== 64'd100) begin n_bad++; $display("FAIL b2b_first got %h want 64", r1); end
        n_cmp++; if (t2 || r2 !== -64'sd6) begin
            n_bad++; $display("FAIL b2b_second got %h want %h", r2, -64'sd6);
        end
    endtask

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        v = {$urandom, $urandom} >> $urandom_range(0, 63);
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = {$urandom, 32'h8000_0000};
            4:       v = -({32'h0, $urandom} >> $urandom_range(0, 31));
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [63:0] a, b, res, want;
        int lat, n, bad_seq;
        bit s, w, r, to;
        for (int i = 0; i < 60; i++) begin
            a = rand_opnd();
            b = rand_opnd();
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            want = ref_div(a, b, s, w, r);
            n = exp_n(a, b, s, w);
            do_op(a, b, s, w, r, res, lat, to);
            n_cmp++; if (to || res !== want) begin
                n_bad++; $display("FAIL rand_result %h/%h s=%0d w=%0d r=%0d got %h want %h",
                                  a, b, s, w, r, res, want);
            end
            n_cmp++; if (lat !== ((n == 0) ? 2 : 5 + n)) begin
                n_bad++; $display("FAIL rand_latency %h/%h got %0d want %0d",
                                  a, b, lat, (n == 0) ? 2 : 5 + n);
            end
            bad_seq = 0;
            foreach (strb_q[j]) if (strb_q[j] != exp_code(j + 1, n)) bad_seq++;
            n_cmp++; if (bad_seq !== 0) begin
                n_bad++; $display("FAIL rand_strobes %h/%h got %0d bad cycles want 0", a, b, bad_seq);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_directed();
        test_flush();
        test_back_pressure();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
